vram_arbiter: RTL and testbench

Shares the single QSPI VRAM controller between three requesters inside `hack_soc`: display line refill (read), CPU screen reads, and posted CPU screen writes. CPU writes are buffered in a small FIFO so the CPU rarely stalls. The display path has priority because it carries a scan-out deadline. A burst cap guarantees that writes drain when the FIFO is full. The block sits between the CPU/display memory-map logic and the VRAM SPI controller.

---
 rtl/vram_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Shares one QSPI VRAM controller between display refill reads, CPU reads and
// posted CPU writes; writes are buffered in a small FIFO and drained in order.
module vram_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned DISP_BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_valid,
    output logic [DATA_WIDTH-1:0] disp_data,
    input  logic                  cpu_rd_req,
    input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
    output logic                  cpu_rd_valid,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    input  logic                  cpu_wr_req,
    input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    output logic                  cpu_wr_full,
    output logic                  mem_start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_busy,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned BurstW = $clog2(DISP_BURST_MAX + 1);

    localparam logic [CntW-1:0]   FifoFull = CntW'(FIFO_DEPTH);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(DISP_BURST_MAX);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    localparam logic [1:0] OwnDisp = 2'd0;
    localparam logic [1:0] OwnCpu  = 2'd1;
    localparam logic [1:0] OwnWr   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_mem [0:FIFO_DEPTH-1];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic                  full_q;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push, fifo_empty;

    logic [BurstW-1:0]     burst_q, burst_d;
    logic                  disp_inflight_q, cpu_inflight_q;
    logic                  disp_valid_q, cpu_valid_q;
    logic [DATA_WIDTH-1:0] disp_data_q, cpu_data_q;

    logic                  grant_wr, grant_disp, grant_cpu;
    logic                  done_here, disp_done, cpu_done;

    assign push       = cpu_wr_req && !full_q;
    assign fifo_empty = (count_q == '0);
    assign {head_addr, head_data} = fifo_mem[rd_ptr_q];

    assign done_here = (state_q == StWait) && mem_done;
    assign disp_done = done_here && (owner_q == OwnDisp);
    assign cpu_done  = done_here && (owner_q == OwnCpu);

    // CPU reads wait for an empty FIFO so they always observe earlier writes.
    always_comb begin
        grant_wr   = 1'b0;
        grant_disp = 1'b0;
        grant_cpu  = 1'b0;
        if (state_q == StIdle) begin
            if (full_q && (burst_q == BurstMax)) begin
                grant_wr = 1'b1;
            end else if (disp_req && !disp_inflight_q) begin
                grant_disp = 1'b1;
            end else if (!fifo_empty) begin
                grant_wr = 1'b1;
            end else if (cpu_rd_req && !cpu_inflight_q) begin
                grant_cpu = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    owner_d     = OwnWr;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                    state_d     = StIssue;
                end else if (grant_disp) begin
                    owner_d     = OwnDisp;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = disp_addr;
                    mem_wdata_d = '0;
                    state_d     = StIssue;
                end else if (grant_cpu) begin
                    owner_d     = OwnCpu;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = cpu_rd_addr;
                    mem_wdata_d = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (!mem_busy) begin
                    mem_start = 1'b1;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (mem_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !grant_wr) begin
            count_d = count_q + CntW'(1);
        end else if (!push && grant_wr) begin
            count_d = count_q - CntW'(1);
        end
    end

    // The burst cap only matters while the FIFO stays full.
    always_comb begin
        burst_d = burst_q;
        if (grant_wr || !full_q) begin
            burst_d = '0;
        end else if (grant_disp && (burst_q != BurstMax)) begin
            burst_d = burst_q + BurstW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            owner_q         <= OwnDisp;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            full_q          <= 1'b0;
            burst_q         <= '0;
            disp_inflight_q <= 1'b0;
            cpu_inflight_q  <= 1'b0;
            disp_valid_q    <= 1'b0;
            cpu_valid_q     <= 1'b0;
            disp_data_q     <= '0;
            cpu_data_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            full_q      <= (count_d == FifoFull);
            burst_q     <= burst_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (grant_wr) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            // Flags drop on mem_done, so they are already clear in the valid cycle.
            if (grant_disp) begin
                disp_inflight_q <= 1'b1;
            end else if (disp_done) begin
                disp_inflight_q <= 1'b0;
            end
            if (grant_cpu) begin
                cpu_inflight_q <= 1'b1;
            end else if (cpu_done) begin
                cpu_inflight_q <= 1'b0;
            end
            disp_valid_q <= disp_done;
            cpu_valid_q  <= cpu_done;
            if (disp_done) begin
                disp_data_q <= mem_rdata;
            end
            if (cpu_done) begin
                cpu_data_q <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cpu_wr_addr, cpu_wr_data};
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_wr_full  = full_q;
    assign disp_valid   = disp_valid_q;
    assign disp_data    = disp_data_q;
    assign cpu_rd_valid = cpu_valid_q;
    assign cpu_rd_data  = cpu_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected commands and
// responses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_vram_arbiter;
    localparam logic [1:0] KCmd  = 2'd0;
    localparam logic [1:0] KDisp = 2'd1;
    localparam logic [1:0] KCpu  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req, cpu_rd_req, cpu_wr_req;
    logic [15:0] disp_addr, cpu_rd_addr, cpu_wr_addr, cpu_wr_data;
    logic        disp_valid, cpu_rd_valid, cpu_wr_full;
    logic [15:0] disp_data, cpu_rd_data;
    logic        mem_start, mem_we, mem_busy, mem_done;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        stall, stray_done;
    logic        mc_busy, mc_done;
    logic [1:0]  mc_cnt;
    logic [15:0] mc_addr;
    bit   [15:0] vram_mem [65536];
    bit          vram_vld [65536];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   start_cnt = 0;
    int   s0, nd;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (16),
        .FIFO_DEPTH    (4),
        .DISP_BURST_MAX(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_valid  (disp_valid),
        .disp_data   (disp_data),
        .cpu_rd_req  (cpu_rd_req),
        .cpu_rd_addr (cpu_rd_addr),
        .cpu_rd_valid(cpu_rd_valid),
        .cpu_rd_data (cpu_rd_data),
        .cpu_wr_req  (cpu_wr_req),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_wr_full (cpu_wr_full),
        .mem_start   (mem_start),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata)
    );

    // SPI controller model: done three cycles after start; unwritten words read addr ^ A5A5.
    assign mem_busy = mc_busy | stall;
    assign mem_done = mc_done | stray_done;

    always @(posedge clk) begin
        if (reset) begin
            mc_busy   <= 1'b0;
            mc_done   <= 1'b0;
            mc_cnt    <= 2'd0;
            mem_rdata <= 16'h0;
        end else begin
            mc_done <= 1'b0;
            if (mem_start) begin
                mc_busy <= 1'b1;
                mc_cnt  <= 2'd2;
                mc_addr <= mem_addr;
                if (mem_we) begin
                    vram_mem[mem_addr] <= mem_wdata;
                    vram_vld[mem_addr] <= 1'b1;
                end
            end else if (mc_busy) begin
                if (mc_cnt == 2'd1) begin
                    mc_busy   <= 1'b0;
                    mc_done   <= 1'b1;
                    mem_rdata <= vram_vld[mc_addr] ? vram_mem[mc_addr] : (mc_addr ^ 16'hA5A5);
                end else begin
                    mc_cnt <= mc_cnt - 2'd1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] k, input logic we, input logic [15:0] a,
                            input logic [15:0] d);
        exp_t e;
        e.kind = k;
        e.we   = we;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_cmd(input logic we, input logic [15:0] a, input logic [15:0] d);
        push_exp(KCmd, we, a, d);
    endtask

    task automatic exp_disp(input logic [15:0] d);
        push_exp(KDisp, 1'b0, 16'h0, d);
    endtask

    task automatic exp_cpu(input logic [15:0] d);
        push_exp(KCpu, 1'b0, 16'h0, d);
    endtask

    task automatic pop_cmp(input string name, input logic [1:0] k, input logic we,
                           input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got kind=%0d we=%0b addr=%h data=%h, required no event",
                     name, k, we, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.we !== we || e.addr !== a || e.data !== d) begin
                n_fail++;
                $display("FAIL %s: got kind=%0d we=%0b addr=%h data=%h, required kind=%0d we=%0b addr=%h data=%h",
                         name, k, we, a, d, e.kind, e.we, e.addr, e.data);
            end
        end
    endtask

    // Monitor: read commands carry no meaningful write data, so it is masked.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_start) begin
                    start_cnt++;
                    pop_cmp("mem_cmd", KCmd, mem_we, mem_addr, mem_we ? mem_wdata : 16'h0);
                end
                if (disp_valid) pop_cmp("disp_rsp", KDisp, 1'b0, 16'h0, disp_data);
                if (cpu_rd_valid) pop_cmp("cpu_rsp", KCpu, 1'b0, 16'h0, cpu_rd_data);
            end
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        @(posedge clk); #1;
        cpu_wr_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        bit got = 0;
        cpu_rd_req  = 1'b1;
        cpu_rd_addr = a;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (cpu_rd_valid) got = 1;
        end
        cpu_rd_req = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_rd_timeout: got no cpu_rd_valid for addr %h, required one", a);
        end
    endtask

    task automatic disp_read(input logic [15:0] a);
        bit got = 0;
        disp_req  = 1'b1;
        disp_addr = a;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (disp_valid) got = 1;
        end
        disp_req = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL disp_timeout: got no disp_valid for addr %h, required one", a);
        end
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        disp_req = 1'b0; cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
        disp_addr = 16'h0; cpu_rd_addr = 16'h0; cpu_wr_addr = 16'h0; cpu_wr_data = 16'h0;
        stall = 1'b0; stray_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_mem_start", 32'(mem_start), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_disp_valid", 32'(disp_valid), 32'h0);
        check("rst_cpu_rd_valid", 32'(cpu_rd_valid), 32'h0);
        check("rst_cpu_wr_full", 32'(cpu_wr_full), 32'h0);
        check("rst_disp_data", 32'(disp_data), 32'h0);
        check("rst_cpu_rd_data", 32'(cpu_rd_data), 32'h0);

        // Single write then read-back of the same word.
        s0 = start_cnt;
        exp_cmd(1'b1, 16'h4000, 16'hBEEF);
        exp_cmd(1'b0, 16'h4000, 16'h0);
        exp_cpu(16'hBEEF);
        cpu_write(16'h4000, 16'hBEEF);
        cpu_read(16'h4000);
        drain("t1_drain");
        check("t1_start_pulses", 32'(start_cnt - s0), 32'd2);

        // Fill the FIFO behind a stalled display read; the fifth strobe is dropped.
        s0 = start_cnt;
        exp_cmd(1'b0, 16'h0200, 16'h0);
        exp_disp(16'hA7A5);
        for (int i = 0; i < 4; i++) exp_cmd(1'b1, 16'h0300 + 16'(i), 16'h1000 + 16'(i));
        stall = 1'b1;
        fork
            disp_read(16'h0200);
            begin
                repeat (2) @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) cpu_write(16'h0300 + 16'(i), 16'h1000 + 16'(i));
                check("t2_full_after_4", 32'(cpu_wr_full), 32'h1);
                cpu_write(16'h03FF, 16'hDEAD);
                check("t2_full_after_5th", 32'(cpu_wr_full), 32'h1);
                stall = 1'b0;
            end
        join
        drain("t2_drain");
        check("t2_start_pulses", 32'(start_cnt - s0), 32'd5);
        check("t2_full_cleared", 32'(cpu_wr_full), 32'h0);

        // Display held with FIFO full: four display grants, one write, display again.
        exp_cmd(1'b0, 16'h0500, 16'h0);
        exp_cpu(16'hA0A5);
        for (int i = 0; i < 4; i++) begin
            exp_cmd(1'b0, 16'h0400, 16'h0);
            exp_disp(16'hA1A5);
        end
        exp_cmd(1'b1, 16'h0600, 16'h2000);
        for (int i = 0; i < 2; i++) begin
            exp_cmd(1'b0, 16'h0400, 16'h0);
            exp_disp(16'hA1A5);
        end
        for (int i = 1; i < 4; i++) exp_cmd(1'b1, 16'h0600 + 16'(i), 16'h2000 + 16'(i));
        stall = 1'b1;
        fork
            cpu_read(16'h0500);
            begin
                repeat (2) @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) cpu_write(16'h0600 + 16'(i), 16'h2000 + 16'(i));
                check("t3_full", 32'(cpu_wr_full), 32'h1);
                disp_addr = 16'h0400;
                disp_req  = 1'b1;
                stall     = 1'b0;
                nd = 0;
                for (int c = 0; c < 400 && nd < 6; c++) begin
                    @(posedge clk); #1;
                    if (disp_valid) nd++;
                end
                disp_req = 1'b0;
                check("t3_disp_count", 32'(nd), 32'd6);
            end
        join
        drain("t3_drain");

        // CPU read waits behind two queued writes and sees the last one.
        exp_cmd(1'b1, 16'h0700, 16'h1111);
        exp_cmd(1'b1, 16'h0701, 16'h2222);
        exp_cmd(1'b1, 16'h0700, 16'h3333);
        exp_cmd(1'b0, 16'h0700, 16'h0);
        exp_cpu(16'h3333);
        stall = 1'b1;
        cpu_write(16'h0700, 16'h1111);
        cpu_write(16'h0701, 16'h2222);
        cpu_write(16'h0700, 16'h3333);
        fork
            cpu_read(16'h0700);
            begin
                repeat (3) @(posedge clk);
                #1;
                stall = 1'b0;
            end
        join
        drain("t4_drain");

        // Display and CPU read in the same cycle: display first.
        exp_cmd(1'b0, 16'h0800, 16'h0);
        exp_disp(16'hADA5);
        exp_cmd(1'b0, 16'h0900, 16'h0);
        exp_cpu(16'hACA5);
        fork
            disp_read(16'h0800);
            cpu_read(16'h0900);
        join
        drain("t5_drain");

        // Reset while waiting on a write, then a stray mem_done.
        exp_cmd(1'b1, 16'h0A00, 16'h5555);
        stall = 1'b1;
        cpu_write(16'h0A00, 16'h5555);
        cpu_write(16'h0A01, 16'h6666);
        cpu_write(16'h0A02, 16'h7777);
        stall = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_mem_start", 32'(mem_start), 32'h0);
        check("t6_mem_we", 32'(mem_we), 32'h0);
        check("t6_mem_addr", 32'(mem_addr), 32'h0);
        check("t6_mem_wdata", 32'(mem_wdata), 32'h0);
        check("t6_disp_data", 32'(disp_data), 32'h0);
        check("t6_cpu_rd_data", 32'(cpu_rd_data), 32'h0);
        check("t6_cpu_wr_full", 32'(cpu_wr_full), 32'h0);
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        check("t6_disp_valid", 32'(disp_valid), 32'h0);
        check("t6_cpu_rd_valid", 32'(cpu_rd_valid), 32'h0);
        @(posedge clk); #1;
        check("t6_mem_start_idle", 32'(mem_start), 32'h0);
        exp_cmd(1'b0, 16'h0B00, 16'h0);
        exp_cpu(16'hAEA5);
        cpu_read(16'h0B00);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
